// File: rtl/l2_req_arb.sv
// Round-robin arbiter sharing the single L2 request port between NREQ L1-side
// requesters; one transaction outstanding, response routed back to its owner.
module l2_req_arb #(
  parameter int NREQ  = 4,
  parameter int ABITS = 32,
  parameter int LBITS = 256,
  parameter int TBITS = 3
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ*TBITS-1:0]   i_req_type,
  input  logic [NREQ*3-1:0]       i_req_size,
  input  logic [NREQ*3-1:0]       i_req_prot,
  input  logic [NREQ*ABITS-1:0]   i_req_addr,
  input  logic [NREQ*LBITS-1:0]   i_req_wdata,
  input  logic [NREQ*LBITS/8-1:0] i_req_wstrb,
  output logic [NREQ-1:0]         o_resp_valid,
  output logic [LBITS-1:0]        o_resp_rdata,
  output logic [1:0]              o_resp_status,
  output logic                    o_l2_req_valid,
  input  logic                    i_l2_req_ready,
  output logic [TBITS-1:0]        o_l2_req_type,
  output logic [2:0]              o_l2_req_size,
  output logic [2:0]              o_l2_req_prot,
  output logic [ABITS-1:0]        o_l2_req_addr,
  output logic [LBITS-1:0]        o_l2_req_wdata,
  output logic [LBITS/8-1:0]      o_l2_req_wstrb,
  input  logic                    i_l2_resp_valid,
  input  logic [LBITS-1:0]        i_l2_resp_rdata,
  input  logic [1:0]              i_l2_resp_status,
  output logic                    o_busy
);

  localparam int SBITS = LBITS / 8;
  localparam int PW    = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_RESP = 2'd2,
    RESPONSE  = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   idx;
  logic            found;

  logic [TBITS-1:0] req_type  [NREQ];
  logic [2:0]       req_size  [NREQ];
  logic [2:0]       req_prot  [NREQ];
  logic [ABITS-1:0] req_addr  [NREQ];
  logic [LBITS-1:0] req_wdata [NREQ];
  logic [SBITS-1:0] req_wstrb [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign req_type[g]  = i_req_type[g*TBITS +: TBITS];
    assign req_size[g]  = i_req_size[g*3 +: 3];
    assign req_prot[g]  = i_req_prot[g*3 +: 3];
    assign req_addr[g]  = i_req_addr[g*ABITS +: ABITS];
    assign req_wdata[g] = i_req_wdata[g*LBITS +: LBITS];
    assign req_wstrb[g] = i_req_wstrb[g*SBITS +: SBITS];
  end

  // First valid requester at or after rr_ptr, wrapping past NREQ-1 to 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NREQ);
      if (!found && i_req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign o_req_ready    = (state == IDLE && found) ? (ONE << winner) : '0;
  assign o_resp_valid   = (state == RESPONSE) ? (ONE << owner) : '0;
  assign o_l2_req_valid = (state == REQUEST);
  assign o_busy         = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      o_l2_req_type  <= '0;
      o_l2_req_size  <= '0;
      o_l2_req_prot  <= '0;
      o_l2_req_addr  <= '0;
      o_l2_req_wdata <= '0;
      o_l2_req_wstrb <= '0;
      o_resp_rdata   <= '0;
      o_resp_status  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            o_l2_req_type  <= req_type[winner];
            o_l2_req_size  <= req_size[winner];
            o_l2_req_prot  <= req_prot[winner];
            o_l2_req_addr  <= req_addr[winner];
            o_l2_req_wdata <= req_wdata[winner];
            o_l2_req_wstrb <= req_wstrb[winner];
            owner          <= winner;
            rr_ptr         <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
            state          <= REQUEST;
          end
        end
        REQUEST: begin
          if (i_l2_req_ready) state <= WAIT_RESP;
        end
        // Response strobes seen in any other state are protocol violations and dropped.
        WAIT_RESP: begin
          if (i_l2_resp_valid) begin
            o_resp_rdata  <= i_l2_resp_rdata;
            o_resp_status <= i_l2_resp_status;
            state         <= RESPONSE;
          end
        end
        RESPONSE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_req_arb.sv
// Self-checking bench for l2_req_arb: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_l2_req_arb;

  localparam int NREQ  = 4;
  localparam int ABITS = 32;
  localparam int LBITS = 64;
  localparam int TBITS = 3;
  localparam int SB    = LBITS / 8;

  logic                  i_clk;
  logic                  i_nrst;
  logic [NREQ-1:0]       i_req_valid;
  logic [NREQ-1:0]       o_req_ready;
  logic [NREQ*TBITS-1:0] i_req_type;
  logic [NREQ*3-1:0]     i_req_size;
  logic [NREQ*3-1:0]     i_req_prot;
  logic [NREQ*ABITS-1:0] i_req_addr;
  logic [NREQ*LBITS-1:0] i_req_wdata;
  logic [NREQ*SB-1:0]    i_req_wstrb;
  logic [NREQ-1:0]       o_resp_valid;
  logic [LBITS-1:0]      o_resp_rdata;
  logic [1:0]            o_resp_status;
  logic                  o_l2_req_valid;
  logic                  i_l2_req_ready;
  logic [TBITS-1:0]      o_l2_req_type;
  logic [2:0]            o_l2_req_size;
  logic [2:0]            o_l2_req_prot;
  logic [ABITS-1:0]      o_l2_req_addr;
  logic [LBITS-1:0]      o_l2_req_wdata;
  logic [SB-1:0]         o_l2_req_wstrb;
  logic                  i_l2_resp_valid;
  logic [LBITS-1:0]      i_l2_resp_rdata;
  logic [1:0]            i_l2_resp_status;
  logic                  o_busy;

  logic [TBITS-1:0] r_type  [NREQ];
  logic [2:0]       r_size  [NREQ];
  logic [2:0]       r_prot  [NREQ];
  logic [ABITS-1:0] r_addr  [NREQ];
  logic [LBITS-1:0] r_wdata [NREQ];
  logic [SB-1:0]    r_wstrb [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign i_req_type[g*TBITS +: TBITS]  = r_type[g];
    assign i_req_size[g*3 +: 3]          = r_size[g];
    assign i_req_prot[g*3 +: 3]          = r_prot[g];
    assign i_req_addr[g*ABITS +: ABITS]  = r_addr[g];
    assign i_req_wdata[g*LBITS +: LBITS] = r_wdata[g];
    assign i_req_wstrb[g*SB +: SB]       = r_wstrb[g];
  end

  int checks   = 0;
  int failures = 0;

  l2_req_arb #(.NREQ(NREQ), .ABITS(ABITS), .LBITS(LBITS), .TBITS(TBITS)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_type(i_req_type), .i_req_size(i_req_size), .i_req_prot(i_req_prot),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_status(o_resp_status),
    .o_l2_req_valid(o_l2_req_valid), .i_l2_req_ready(i_l2_req_ready),
    .o_l2_req_type(o_l2_req_type), .o_l2_req_size(o_l2_req_size), .o_l2_req_prot(o_l2_req_prot),
    .o_l2_req_addr(o_l2_req_addr), .o_l2_req_wdata(o_l2_req_wdata), .o_l2_req_wstrb(o_l2_req_wstrb),
    .i_l2_resp_valid(i_l2_resp_valid), .i_l2_resp_rdata(i_l2_resp_rdata),
    .i_l2_resp_status(i_l2_resp_status), .o_busy(o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic set_req(input logic [1:0] k, input logic [ABITS-1:0] addr, input logic [LBITS-1:0] wdata,
                         input logic [SB-1:0] wstrb, input logic [2:0] typ, input logic [2:0] size,
                         input logic [2:0] prot);
    r_addr[k]  = addr;
    r_wdata[k] = wdata;
    r_wstrb[k] = wstrb;
    r_type[k]  = typ;
    r_size[k]  = size;
    r_prot[k]  = prot;
  endtask

  task automatic do_reset();
    i_nrst           = 1'b0;
    i_req_valid      = '0;
    i_l2_req_ready   = 1'b0;
    i_l2_resp_valid  = 1'b0;
    i_l2_resp_rdata  = '0;
    i_l2_resp_status = 2'd0;
    for (int k = 0; k < NREQ; k++) set_req(2'(k), '0, '0, '0, '0, '0, '0);
    repeat (2) @(negedge i_clk);
    i_nrst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", o_busy); end
    checks++; if (o_l2_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_l2_valid: got %0b expected 0", o_l2_req_valid); end
    checks++; if (o_resp_valid !== 4'b0) begin failures++; $display("[TB] FAIL reset_resp_valid: got %b expected 0000", o_resp_valid); end
    checks++; if (o_req_ready !== 4'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0000", o_req_ready); end
    checks++; if (o_resp_rdata !== '0 || o_resp_status !== 2'd0) begin failures++; $display("[TB] FAIL reset_resp_data: got %h/%0d expected 0/0", o_resp_rdata, o_resp_status); end
    checks++; if (o_l2_req_addr !== '0 || o_l2_req_wdata !== '0 || o_l2_req_type !== '0) begin
      failures++; $display("[TB] FAIL reset_fields: got addr=%h wdata=%h expected 0", o_l2_req_addr, o_l2_req_wdata); end
  endtask

  task automatic test_single_write();
    logic [LBITS-1:0] wd, rd;
    wd = {$urandom, $urandom};
    rd = {$urandom, $urandom};
    do_reset();
    i_l2_req_ready = 1'b1;
    set_req(2'd2, 32'h8000_1000, wd, 8'hFF, 3'd1, 3'd6, 3'd2);
    i_req_valid = 4'b0100;
    #1;
    checks++; if (o_req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL single_ready: got %b expected 0100", o_req_ready); end
    @(negedge i_clk);
    i_req_valid = '0;
    #1;
    checks++; if (o_l2_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_l2_valid: got %0b expected 1", o_l2_req_valid); end
    checks++; if (o_l2_req_addr !== 32'h8000_1000) begin failures++; $display("[TB] FAIL single_addr: got %h expected 80001000", o_l2_req_addr); end
    checks++; if (o_l2_req_wstrb !== 8'hFF || o_l2_req_wdata !== wd) begin failures++; $display("[TB] FAIL single_wdata: got %h/%h expected %h/ff", o_l2_req_wdata, o_l2_req_wstrb, wd); end
    checks++; if (o_l2_req_type !== 3'd1 || o_l2_req_size !== 3'd6 || o_l2_req_prot !== 3'd2) begin
      failures++; $display("[TB] FAIL single_attr: got %0d/%0d/%0d expected 1/6/2", o_l2_req_type, o_l2_req_size, o_l2_req_prot); end
    @(negedge i_clk);
    i_l2_resp_valid  = 1'b1;
    i_l2_resp_rdata  = rd;
    i_l2_resp_status = 2'd0;
    #1;
    checks++; if (o_l2_req_valid !== 1'b0 || o_busy !== 1'b1) begin failures++; $display("[TB] FAIL single_wait: got l2v=%0b busy=%0b expected 0/1", o_l2_req_valid, o_busy); end
    @(negedge i_clk);
    i_l2_resp_valid = 1'b0;
    #1;
    checks++; if (o_resp_valid !== 4'b0100) begin failures++; $display("[TB] FAIL single_resp_valid: got %b expected 0100", o_resp_valid); end
    checks++; if (o_resp_rdata !== rd || o_resp_status !== 2'd0) begin failures++; $display("[TB] FAIL single_resp_data: got %h/%0d expected %h/0", o_resp_rdata, o_resp_status, rd); end
    @(negedge i_clk);
    #1;
    checks++; if (o_resp_valid !== 4'b0 || o_busy !== 1'b0) begin failures++; $display("[TB] FAIL single_turnaround: got rv=%b busy=%0b expected 0000/0", o_resp_valid, o_busy); end
  endtask

  task automatic test_round_robin();
    int g, r;
    logic [3:0] exp;
    do_reset();
    for (int k = 0; k < NREQ; k++) set_req(2'(k), 32'h1000 + 32'(k), 64'(k), 8'h0F, 3'd0, 3'd3, 3'd0);
    i_l2_req_ready  = 1'b1;
    i_l2_resp_valid = 1'b1;
    i_req_valid     = 4'hF;
    g = 0;
    r = 0;
    for (int cyc = 0; cyc < 60 && (g < 6 || r < 6); cyc++) begin
      #1;
      if (o_req_ready != 4'b0) begin
        exp = 4'b0001 << (g % NREQ);
        checks++; if (o_req_ready !== exp) begin failures++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", g, o_req_ready, exp); end
        g++;
      end
      if (o_resp_valid != 4'b0) begin
        exp = 4'b0001 << (r % NREQ);
        checks++; if (o_resp_valid !== exp) begin failures++; $display("[TB] FAIL rr_resp%0d: got %b expected %b", r, o_resp_valid, exp); end
        r++;
      end
      @(negedge i_clk);
    end
    i_req_valid     = '0;
    i_l2_resp_valid = 1'b0;
    checks++; if (g < 6 || r < 6) begin failures++; $display("[TB] FAIL rr_timeout: got grants=%0d resps=%0d expected 6/6", g, r); end
  endtask

  task automatic test_wrap();
    int exp_order [3] = '{2, 3, 0};
    int g;
    logic [3:0] gm, exp;
    do_reset();
    i_l2_req_ready  = 1'b1;
    i_l2_resp_valid = 1'b1;
    i_req_valid     = 4'b0100;
    g = 0;
    for (int cyc = 0; cyc < 40 && g < 3; cyc++) begin
      #1;
      gm = o_req_ready;
      if (gm != 4'b0) begin
        exp = 4'b0001 << exp_order[g];
        checks++; if (gm !== exp) begin failures++; $display("[TB] FAIL wrap_grant%0d: got %b expected %b", g, gm, exp); end
        g++;
      end
      @(negedge i_clk);
      i_req_valid = i_req_valid & ~gm;
      if (gm == 4'b0100) i_req_valid = 4'b1001;
    end
    i_req_valid     = '0;
    i_l2_resp_valid = 1'b0;
    checks++; if (g != 3) begin failures++; $display("[TB] FAIL wrap_timeout: got grants=%0d expected 3", g); end
  endtask

  task automatic test_l2_stall();
    logic [ABITS-1:0] a;
    logic [LBITS-1:0] wd;
    a  = $urandom;
    wd = {$urandom, $urandom};
    do_reset();
    set_req(2'd1, a, wd, 8'hA5, 3'd2, 3'd3, 3'd1);
    set_req(2'd3, 32'hDEAD_0000, 64'h1, 8'h01, 3'd0, 3'd0, 3'd0);
    i_req_valid = 4'b0010;
    @(negedge i_clk);
    i_req_valid = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (o_l2_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_l2_valid%0d: got %0b expected 1", i, o_l2_req_valid); end
      checks++; if (o_l2_req_addr !== a || o_l2_req_wdata !== wd || o_l2_req_wstrb !== 8'hA5) begin
        failures++; $display("[TB] FAIL stall_fields%0d: got %h/%h expected %h/%h", i, o_l2_req_addr, o_l2_req_wdata, a, wd); end
      checks++; if (o_req_ready !== 4'b0) begin failures++; $display("[TB] FAIL stall_ready%0d: got %b expected 0000", i, o_req_ready); end
      @(negedge i_clk);
    end
    i_l2_req_ready = 1'b1;
    @(negedge i_clk);
    i_l2_req_ready  = 1'b0;
    i_l2_resp_valid = 1'b1;
    @(negedge i_clk);
    i_l2_resp_valid = 1'b0;
    #1;
    checks++; if (o_resp_valid !== 4'b0010) begin failures++; $display("[TB] FAIL stall_resp: got %b expected 0010", o_resp_valid); end
    @(negedge i_clk);
    #1;
    checks++; if (o_req_ready !== 4'b1000) begin failures++; $display("[TB] FAIL stall_next_ready: got %b expected 1000", o_req_ready); end
    i_req_valid = '0;
  endtask

  task automatic test_spurious_decerr();
    logic [LBITS-1:0] rd;
    rd = {$urandom, $urandom};
    do_reset();
    set_req(2'd0, 32'h4000_0040, 64'h0, 8'h00, 3'd0, 3'd6, 3'd0);
    i_req_valid = 4'b0001;
    @(negedge i_clk);
    i_req_valid      = '0;
    i_l2_resp_valid  = 1'b1;
    i_l2_resp_status = 2'd2;
    i_l2_resp_rdata  = ~rd;
    @(negedge i_clk);
    #1;
    checks++; if (o_l2_req_valid !== 1'b1 || o_resp_valid !== 4'b0) begin
      failures++; $display("[TB] FAIL spurious_ignored: got l2v=%0b rv=%b expected 1/0000", o_l2_req_valid, o_resp_valid); end
    checks++; if (o_resp_status !== 2'd0) begin failures++; $display("[TB] FAIL spurious_status: got %0d expected 0", o_resp_status); end
    i_l2_resp_valid = 1'b0;
    i_l2_req_ready  = 1'b1;
    @(negedge i_clk);
    i_l2_req_ready = 1'b0;
    #1;
    checks++; if (o_l2_req_valid !== 1'b0 || o_resp_valid !== 4'b0) begin
      failures++; $display("[TB] FAIL spurious_wait: got l2v=%0b rv=%b expected 0/0000", o_l2_req_valid, o_resp_valid); end
    i_l2_resp_valid  = 1'b1;
    i_l2_resp_status = 2'd3;
    i_l2_resp_rdata  = rd;
    @(negedge i_clk);
    i_l2_resp_valid = 1'b0;
    #1;
    checks++; if (o_resp_valid !== 4'b0001) begin failures++; $display("[TB] FAIL decerr_valid: got %b expected 0001", o_resp_valid); end
    checks++; if (o_resp_status !== 2'd3 || o_resp_rdata !== rd) begin
      failures++; $display("[TB] FAIL decerr_data: got %0d/%h expected 3/%h", o_resp_status, o_resp_rdata, rd); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_l2_req_ready = 1'b1;
    set_req(2'd1, 32'h1234_5678, 64'hCAFE, 8'h3C, 3'd4, 3'd2, 3'd5);
    i_req_valid = 4'b0010;
    @(negedge i_clk);
    i_req_valid = '0;
    @(negedge i_clk);
    #1;
    checks++; if (o_busy !== 1'b1 || o_l2_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_in_wait: got busy=%0b l2v=%0b expected 1/0", o_busy, o_l2_req_valid); end
    i_nrst          = 1'b0;
    i_l2_resp_valid = 1'b1;
    #1;
    checks++; if (o_busy !== 1'b0 || o_l2_req_valid !== 1'b0 || o_resp_valid !== 4'b0) begin
      failures++; $display("[TB] FAIL mid_reset_ctrl: got busy=%0b l2v=%0b rv=%b expected 0/0/0000", o_busy, o_l2_req_valid, o_resp_valid); end
    checks++; if (o_l2_req_addr !== '0 || o_l2_req_wdata !== '0 || o_l2_req_wstrb !== '0 || o_l2_req_type !== '0) begin
      failures++; $display("[TB] FAIL mid_reset_fields: got %h/%h expected 0/0", o_l2_req_addr, o_l2_req_wdata); end
    @(negedge i_clk);
    i_nrst          = 1'b1;
    i_l2_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      #1;
      checks++; if (o_resp_valid !== 4'b0 || o_busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_no_resp%0d: got rv=%b busy=%0b expected 0000/0", i, o_resp_valid, o_busy); end
    end
    i_req_valid = 4'b0110;
    #1;
    checks++; if (o_req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL mid_rr_restart: got %b expected 0010", o_req_ready); end
    i_req_valid = '0;
  endtask

  // Transaction-level reference: at most one outstanding transaction, tracked by
  // whether it is still offered to L2, awaiting data, or being returned.
  task automatic test_random();
    bit               pend [NREQ];
    logic [3:0]       granted, exp_ready, exp_resp;
    bit               m_busy, m_sent, m_done;
    int               m_rr, m_owner, win, j, st;
    logic [ABITS-1:0] m_addr;
    logic [LBITS-1:0] m_wdata, m_rdata;
    logic [SB-1:0]    m_wstrb;
    logic [2:0]       m_type, m_size, m_prot;
    logic [1:0]       m_status;
    do_reset();
    for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
    granted = '0;
    m_busy = 1'b0; m_sent = 1'b0; m_done = 1'b0;
    m_rr = 0; m_owner = 0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0; m_type = '0; m_size = '0; m_prot = '0;
    m_rdata = '0; m_status = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (granted[k]) begin pend[k] = 1'b0; i_req_valid[2'(k)] = 1'b0; end
        else if (pend[k] && $urandom_range(0, 15) == 0) begin pend[k] = 1'b0; i_req_valid[2'(k)] = 1'b0; end
        else if (!pend[k] && $urandom_range(0, 3) == 0) begin
          set_req(2'(k), $urandom, {$urandom, $urandom}, 8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
          pend[k] = 1'b1;
          i_req_valid[2'(k)] = 1'b1;
        end
      end
      granted          = '0;
      i_l2_req_ready   = ($urandom_range(0, 2) != 0);
      i_l2_resp_valid  = ($urandom_range(0, 2) == 0);
      i_l2_resp_rdata  = {$urandom, $urandom};
      st               = $urandom_range(0, 2);
      i_l2_resp_status = (st == 0) ? 2'd0 : 2'(st + 1);
      #1;
      win = -1;
      if (!m_busy)
        for (int i = 0; i < NREQ; i++) begin
          j = (m_rr + i) % NREQ;
          if (win < 0 && i_req_valid[2'(j)]) win = j;
        end
      exp_ready = (win >= 0) ? (4'b0001 << win) : 4'b0000;
      exp_resp  = (m_busy && m_done) ? (4'b0001 << m_owner) : 4'b0000;
      checks++; if (o_req_ready !== exp_ready) begin failures++; $display("[TB] FAIL rand_ready@%0d: got %b expected %b", cyc, o_req_ready, exp_ready); end
      checks++; if (o_busy !== m_busy) begin failures++; $display("[TB] FAIL rand_busy@%0d: got %0b expected %0b", cyc, o_busy, m_busy); end
      checks++; if (o_l2_req_valid !== (m_busy && !m_sent)) begin failures++; $display("[TB] FAIL rand_l2_valid@%0d: got %0b expected %0b", cyc, o_l2_req_valid, m_busy && !m_sent); end
      checks++; if (o_resp_valid !== exp_resp) begin failures++; $display("[TB] FAIL rand_resp_valid@%0d: got %b expected %b", cyc, o_resp_valid, exp_resp); end
      if (m_busy && !m_sent) begin
        checks++;
        if (o_l2_req_addr !== m_addr || o_l2_req_wdata !== m_wdata || o_l2_req_wstrb !== m_wstrb ||
            o_l2_req_type !== m_type || o_l2_req_size !== m_size || o_l2_req_prot !== m_prot) begin
          failures++; $display("[TB] FAIL rand_fields@%0d: got addr=%h wdata=%h expected addr=%h wdata=%h", cyc, o_l2_req_addr, o_l2_req_wdata, m_addr, m_wdata); end
      end
      if (m_busy && m_done) begin
        checks++; if (o_resp_rdata !== m_rdata || o_resp_status !== m_status) begin
          failures++; $display("[TB] FAIL rand_resp_data@%0d: got %h/%0d expected %h/%0d", cyc, o_resp_rdata, o_resp_status, m_rdata, m_status); end
      end
      if (!m_busy) begin
        if (win >= 0) begin
          m_addr = r_addr[2'(win)]; m_wdata = r_wdata[2'(win)]; m_wstrb = r_wstrb[2'(win)];
          m_type = r_type[2'(win)]; m_size = r_size[2'(win)]; m_prot = r_prot[2'(win)];
          m_owner = win;
          m_rr    = (win + 1) % NREQ;
          m_busy  = 1'b1; m_sent = 1'b0; m_done = 1'b0;
          granted = exp_ready;
        end
      end else if (!m_sent) begin
        if (i_l2_req_ready) m_sent = 1'b1;
      end else if (!m_done) begin
        if (i_l2_resp_valid) begin m_done = 1'b1; m_rdata = i_l2_resp_rdata; m_status = i_l2_resp_status; end
      end else begin
        m_busy = 1'b0;
      end
      @(negedge i_clk);
    end
    i_req_valid = '0;
  endtask

  initial begin
    i_nrst = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_wrap();
    test_l2_stall();
    test_spurious_decerr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
